memory_bus_responder: RTL
=========================

MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait cycles inserted before each response (range 0..7).
REQ-002 Parameter RESET_VECTOR, default 16'h0200, SHALL set the 16-bit value returned from vector addresses FFFC/FFFD.
REQ-003 Parameter IRQ_VECTOR, default 16'h0300, SHALL set the 16-bit value returned from vector addresses FFFE/FFFF and FFFA/FFFB.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 nrst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 accessValid  input  1  SHALL mark a bus access request whose address, direction and write data are held stable until ready.
REQ-007 readNotWrite  input  1  SHALL select the access type: 1 = read, 0 = write.
REQ-008 externalAddressBusLowInput  input  8  SHALL be the address low byte driven by the CPU core.
REQ-009 externalAddressBusHighInput  input  8  SHALL be the address high byte driven by the CPU core.
REQ-010 dataBusInput  input  8  SHALL be the write data.
REQ-011 dataBusOutput  output  8  SHALL be the read data, valid only while ready=1 on a read.
REQ-012 ready  output  1  SHALL pulse high for one cycle when an access completes.
REQ-013 unmappedAccess  output  1  SHALL pulse high together with ready when the completed access hit no mapped region.

Function
REQ-014 Address map SHALL be: 0000-01FF internal 512-byte RAM (zero page + stack page); FFFA-FFFF read-only vector bytes, little-endian; all else unmapped.
REQ-015 The FSM SHALL have states IDLE, WAIT, RESPOND.
REQ-016 IDLE SHALL move to WAIT when accessValid=1 and WAIT_CYCLES>0, or directly to RESPOND when accessValid=1 and WAIT_CYCLES=0; otherwise it stays in IDLE.
REQ-017 On entering WAIT a 3-bit counter SHALL load WAIT_CYCLES-1, decrement each cycle, and move to RESPOND after the cycle in which it reads 0.
REQ-018 RESPOND SHALL last exactly one cycle with ready=1, then return to IDLE.
REQ-019 ready SHALL therefore assert WAIT_CYCLES+1 cycles after the edge at which accessValid is first sampled high.
REQ-020 A new access SHALL NOT be sampled in the RESPOND cycle; back-to-back accesses start from IDLE on the following cycle.
REQ-021 A read SHALL drive dataBusOutput with the addressed byte during RESPOND and 8'h00 otherwise.
REQ-022 An unmapped read SHALL return 8'hFF.
REQ-023 A RAM write SHALL commit at the rising edge that ends RESPOND.
REQ-024 Writes to vector or unmapped addresses SHALL be discarded and SHALL leave RAM unchanged.
REQ-025 accessValid dropping during WAIT SHALL abort the access: return to IDLE, with no ready pulse and no write.
REQ-026 Address or data changes during WAIT are protocol violations; the values sampled in RESPOND SHALL be used.

Reset
REQ-027 While nrst=0, the FSM SHALL be in IDLE, the counter 0, ready=0, unmappedAccess=0 and dataBusOutput=8'h00.
REQ-028 Reset mid-access SHALL abandon the access without committing the write.
REQ-029 RAM contents SHALL NOT be reset and are undefined after power-up.

Configuration
REQ-030 With macro MEMORY_BUS_WAIT_STATES_EN defined, WAIT_CYCLES SHALL apply as specified above.
REQ-031 Without MEMORY_BUS_WAIT_STATES_EN, the WAIT state and counter SHALL be compiled out and every access SHALL complete with a ready pulse one cycle after sampling, regardless of WAIT_CYCLES.

Structure
REQ-032 The FSM state enum, region-decode enum, vector addresses (FFFA-FFFF) and unmapped read value 8'hFF SHALL live in the shared constants package.
REQ-033 RAM storage SHALL be one sub-module, responder_ram: 512x8, synchronous write, combinational read, no reset.

Verification
REQ-034 Reset release, WAIT_CYCLES=2, read FFFC then FFFD -> ready on cycle 3 of each access; data 8'h00 then 8'h02.
REQ-035 Write 8'hA5 to 01FF, then read 01FF -> read returns 8'hA5; unmappedAccess stays 0.
REQ-036 Write 8'h3C to 8000, then read 8000 -> unmappedAccess pulses on both accesses; read data 8'hFF; RAM unchanged.
REQ-037 accessValid dropped after 1 wait cycle on a write of 8'h11 to 0010 -> no ready pulse; a following read of 0010 returns the prior value.
REQ-038 nrst asserted during WAIT of a write to 0020 -> outputs 0 immediately; the write does not commit.
REQ-039 Build without MEMORY_BUS_WAIT_STATES_EN, WAIT_CYCLES=5, read 0000 -> ready one cycle after sampling.

Source files
------------

// File: rtl/memory_bus_responder_pkg.sv
// Shared constants for the memory bus responder: FSM states, region decode,
// vector addresses and the value returned for unmapped reads.
// No ports; imported by the responder, its RAM and the testbench.
package memory_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM      = 2'd0,
    RGN_VECTOR   = 2'd1,
    RGN_UNMAPPED = 2'd2
  } region_t;

  localparam int          RAM_ADDR_W = 9;
  localparam int          RAM_DEPTH  = 512;
  localparam logic [15:0] RAM_LAST   = 16'h01FF;

  // Vector bytes are little-endian: even address holds the low byte.
  localparam logic [15:0] VEC_NMI_LO   = 16'hFFFA;
  localparam logic [15:0] VEC_NMI_HI   = 16'hFFFB;
  localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;
  localparam logic [15:0] VEC_IRQ_LO   = 16'hFFFE;
  localparam logic [15:0] VEC_IRQ_HI   = 16'hFFFF;

  localparam logic [7:0] UNMAPPED_READ_VALUE = 8'hFF;

  function automatic region_t decode_region(input logic [15:0] addr);
    region_t rgn;
    rgn = RGN_UNMAPPED;
    if (addr <= RAM_LAST) begin
      rgn = RGN_RAM;
    end else if (addr >= VEC_NMI_LO) begin
      rgn = RGN_VECTOR;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/memory_bus_responder_if.sv
// CPU-side memory bus between a core (master) and the responder (slave).
// Ports: accessValid/readNotWrite/address/dataBusInput from the master;
//        dataBusOutput/ready/unmappedAccess back from the slave.
interface memory_bus_responder_if;

  logic       accessValid;
  logic       readNotWrite;
  logic [7:0] externalAddressBusLowInput;
  logic [7:0] externalAddressBusHighInput;
  logic [7:0] dataBusInput;
  logic [7:0] dataBusOutput;
  logic       ready;
  logic       unmappedAccess;

  modport master (
    output accessValid, readNotWrite, externalAddressBusLowInput,
           externalAddressBusHighInput, dataBusInput,
    input  dataBusOutput, ready, unmappedAccess
  );

  modport slave (
    input  accessValid, readNotWrite, externalAddressBusLowInput,
           externalAddressBusHighInput, dataBusInput,
    output dataBusOutput, ready, unmappedAccess
  );

endinterface

// File: rtl/memory_bus_responder_ram.sv
// responder_ram: 512x8 storage, synchronous write, combinational read, no reset.
// Latency: write lands at the clock edge with we=1; read is same-cycle.
// Ports: clk, we, addr[8:0], wdata[7:0] in; rdata[7:0] out.
module responder_ram
  import memory_bus_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [RAM_DEPTH];

  // Contents are deliberately left unreset; power-up values are undefined.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_bus_responder.sv
// Memory bus responder: 512B RAM at 0000-01FF, read-only vectors at FFFA-FFFF.
// Latency: ready WAIT_CYCLES+1 cycles after sampling with MEMORY_BUS_WAIT_STATES_EN,
// else 1 cycle. Backpressure: master holds request until the one-cycle ready pulse.
// Ports: clk, nrst (async active-low), bus (slave modport of memory_bus_responder_if).
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter int          WAIT_CYCLES  = 2,
  parameter logic [15:0] RESET_VECTOR = 16'h0200,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0300
) (
  input  logic                        clk,
  input  logic                        nrst,
  memory_bus_responder_if.slave       bus
);

  state_t     state;
  state_t     state_nxt;
  logic [15:0] addr;
  region_t    region;
  logic       respond;
  logic [7:0] ram_rdata;
  logic [7:0] vec_byte;
  logic [7:0] read_byte;
  logic       ram_we;

  assign addr    = {bus.externalAddressBusHighInput, bus.externalAddressBusLowInput};
  assign region  = decode_region(addr);
  assign respond = (state == ST_RESPOND);

  always_comb begin
    vec_byte = 8'h00;
    case (addr)
      VEC_NMI_LO:   vec_byte = IRQ_VECTOR[7:0];
      VEC_NMI_HI:   vec_byte = IRQ_VECTOR[15:8];
      VEC_RESET_LO: vec_byte = RESET_VECTOR[7:0];
      VEC_RESET_HI: vec_byte = RESET_VECTOR[15:8];
      VEC_IRQ_LO:   vec_byte = IRQ_VECTOR[7:0];
      VEC_IRQ_HI:   vec_byte = IRQ_VECTOR[15:8];
      default:      vec_byte = 8'h00;
    endcase
  end

  always_comb begin
    read_byte = UNMAPPED_READ_VALUE;
    case (region)
      RGN_RAM:    read_byte = ram_rdata;
      RGN_VECTOR: read_byte = vec_byte;
      default:    read_byte = UNMAPPED_READ_VALUE;
    endcase
  end

  // Address and data are taken as they stand in RESPOND, so the write
  // lands on the edge that ends RESPOND.
  always_comb begin
    bus.ready          = respond;
    bus.unmappedAccess = respond && (region == RGN_UNMAPPED);
    bus.dataBusOutput  = (respond && bus.readNotWrite) ? read_byte : 8'h00;
    ram_we             = respond && !bus.readNotWrite && (region == RGN_RAM);
  end

  responder_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr[RAM_ADDR_W-1:0]),
    .wdata (bus.dataBusInput),
    .rdata (ram_rdata)
  );

`ifdef MEMORY_BUS_WAIT_STATES_EN
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

  logic [2:0] wait_cnt;
  logic [2:0] wait_cnt_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.accessValid) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = ST_RESPOND;
          end
        end
      end
      ST_WAIT: begin
        // Dropping the request aborts before any write can commit.
        if (!bus.accessValid) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = 3'd0;
        end else if (wait_cnt == 3'd0) begin
          state_nxt = ST_RESPOND;
        end else begin
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end
      ST_RESPOND: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end
`else
  // Wait states are compiled out; WAIT_CYCLES is accepted but has no effect.
  localparam logic [2:0] WAIT_CFG = 3'(WAIT_CYCLES);
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^WAIT_CFG;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.accessValid) state_nxt = ST_RESPOND;
      ST_RESPOND: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end
`endif

endmodule
